// File: rtl/life_pkg.sv
// Shared types and widths for the life/respawn controller.
package life_pkg;
    localparam int LIVES_W = 3;
    localparam int FC_W    = 8;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        DYING  = 2'd1,
        INVULN = 2'd2,
        OVER   = 2'd3
    } life_state_t;
endpackage

// File: rtl/life_respawn_frame_timer.sv
// Frame counter: counts startOfFrame pulses, flags the last frame of a phase.
module frame_timer #(
    parameter int FC_W = 8
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            clear,
    input  logic            startOfFrame,
    input  logic [FC_W-1:0] limit,
    output logic [FC_W-1:0] count,
    output logic            done
);
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (startOfFrame) begin
            count <= count + FC_W'(1);
        end
    end

    assign done = startOfFrame && (count == (limit - FC_W'(1)));
endmodule

// File: rtl/life_respawn_controller.sv
// Player life count and death/invulnerability/game-over sequencing.
// Optional extra-life support is enabled by defining LIFE_EXTRA_LIFE_EN.
//
// state  | meaning
// ALIVE  | player active and killable
// DYING  | death animation, aliens frozen
// INVULN | respawned, cannot be killed, aliens moving
// OVER   | no lives left, waits for restart
module life_respawn_controller
    import life_pkg::*;
#(
    parameter int INIT_LIVES    = 3,
    parameter int MAX_LIVES     = 5,
    parameter int DYING_FRAMES  = 60,
    parameter int INVULN_FRAMES = 90
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               restart_gameN,
    input  logic               player_died,
    input  logic               extra_life,
    output logic [LIVES_W-1:0] lives,
    output logic               player_awake,
    output logic               respawn_pulse,
    output logic               aliens_freeze,
    output logic               no_lives_left
);
    life_state_t        state, state_next;
    logic [LIVES_W-1:0] lives_dec, lives_next;
    logic               respawn_next, awake_next, freeze_next, over_next;
    logic [FC_W-1:0]    fc, limit;
    logic               timer_clear, timer_done;
    logic               extra;
    logic               unused_sink;

`ifdef LIFE_EXTRA_LIFE_EN
    assign extra       = extra_life && (state != OVER);
    assign unused_sink = ^fc;
`else
    assign extra       = 1'b0;
    assign unused_sink = ^{fc, extra_life};
`endif

    always_comb begin
        limit = '0;
        case (state)
            DYING:   limit = FC_W'(DYING_FRAMES);
            INVULN:  limit = FC_W'(INVULN_FRAMES);
            default: limit = '0;
        endcase
    end

    // Entering a new state clears fc, so a coinciding frame pulse is not counted.
    assign timer_clear = !restart_gameN || (state_next != state) ||
                         (state == ALIVE) || (state == OVER);

    frame_timer #(.FC_W(FC_W)) u_frame_timer (
        .clk          (clk),
        .resetN       (resetN),
        .clear        (timer_clear),
        .startOfFrame (startOfFrame),
        .limit        (limit),
        .count        (fc),
        .done         (timer_done)
    );

    always_comb begin
        state_next   = state;
        respawn_next = 1'b0;
        lives_dec    = lives;

        if (state == ALIVE && player_died && lives != '0) begin
            lives_dec = lives - LIVES_W'(1);
        end

        // Extra life is applied after the death decrement and before the game-over test.
        if (extra && (lives_dec < LIVES_W'(MAX_LIVES))) begin
            lives_next = lives_dec + LIVES_W'(1);
        end else begin
            lives_next = lives_dec;
        end

        case (state)
            ALIVE: begin
                if (player_died) begin
                    state_next = DYING;
                end
            end
            DYING: begin
                if (timer_done) begin
                    if (lives_next == '0) begin
                        state_next = OVER;
                    end else begin
                        state_next   = INVULN;
                        respawn_next = 1'b1;
                    end
                end
            end
            INVULN: begin
                if (timer_done) begin
                    state_next = ALIVE;
                end
            end
            default: state_next = OVER;
        endcase

        if (!restart_gameN) begin
            state_next   = ALIVE;
            lives_next   = LIVES_W'(INIT_LIVES);
            respawn_next = 1'b0;
        end

        awake_next  = (state_next == ALIVE);
        freeze_next = (state_next == DYING) || (state_next == OVER);
        over_next   = (state_next == OVER);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= ALIVE;
            lives         <= LIVES_W'(INIT_LIVES);
            player_awake  <= 1'b1;
            respawn_pulse <= 1'b0;
            aliens_freeze <= 1'b0;
            no_lives_left <= 1'b0;
        end else begin
            state         <= state_next;
            lives         <= lives_next;
            player_awake  <= awake_next;
            respawn_pulse <= respawn_next;
            aliens_freeze <= freeze_next;
            no_lives_left <= over_next;
        end
    end
endmodule

// File: tb/tb_life_respawn_controller.sv
// Directed bench for life_respawn_controller; extra-life steps run when LIFE_EXTRA_LIFE_EN is defined.
module tb_life_respawn_controller;
    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       restart_gameN;
    logic       player_died;
    logic       extra_life;
    logic [2:0] lives;
    logic       player_awake;
    logic       respawn_pulse;
    logic       aliens_freeze;
    logic       no_lives_left;

    int total = 0;
    int bad   = 0;
    int rs_cnt;

    always #5 clk = ~clk;

    life_respawn_controller dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .restart_gameN (restart_gameN),
        .player_died   (player_died),
        .extra_life    (extra_life),
        .lives         (lives),
        .player_awake  (player_awake),
        .respawn_pulse (respawn_pulse),
        .aliens_freeze (aliens_freeze),
        .no_lives_left (no_lives_left)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (respawn_pulse === 1'b1) rs_cnt++;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
            step();
        end
    endtask

    task automatic die_and_respawn();
        player_died = 1'b1;
        step();
        player_died = 1'b0;
        frames(60);
        frames(90);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN        = 1'b0;
        startOfFrame  = 1'b0;
        restart_gameN = 1'b1;
        player_died   = 1'b0;
        extra_life    = 1'b0;
        rs_cnt        = 0;
        #12;
        chk("rst_lives", lives, 3);
        chk("rst_awake", player_awake, 1);
        chk("rst_freeze", aliens_freeze, 0);
        chk("rst_respawn", respawn_pulse, 0);
        chk("rst_over", no_lives_left, 0);
        #5 resetN = 1'b1;
        step();
        chk("idle_lives", lives, 3);

        // Held collision costs one life
        player_died = 1'b1;
        step();
        chk("die1_lives", lives, 2);
        chk("die1_awake", player_awake, 0);
        chk("die1_freeze", aliens_freeze, 1);
        step(); step(); step(); step();
        player_died = 1'b0;
        chk("die1_held_lives", lives, 2);

        rs_cnt = 0;
        frames(59);
        chk("dying59_respawn_cnt", rs_cnt, 0);
        chk("dying59_freeze", aliens_freeze, 1);
        frames(1);
        chk("dying60_respawn_cnt", rs_cnt, 1);
        chk("invuln_freeze", aliens_freeze, 0);
        chk("invuln_awake", player_awake, 0);

        player_died = 1'b1;
        step(); step();
        player_died = 1'b0;
        chk("invuln_die_lives", lives, 2);
        chk("invuln_die_freeze", aliens_freeze, 0);

        frames(89);
        chk("invuln89_awake", player_awake, 0);
        frames(1);
        chk("invuln90_awake", player_awake, 1);
        chk("alive_lives", lives, 2);

        die_and_respawn();
        chk("die2_lives", lives, 1);
        chk("die2_awake", player_awake, 1);

        // Third death leads to game over, no respawn
        player_died = 1'b1;
        step();
        player_died = 1'b0;
        chk("die3_lives", lives, 0);
        rs_cnt = 0;
        frames(60);
        chk("over_respawn_cnt", rs_cnt, 0);
        chk("over_flag", no_lives_left, 1);
        chk("over_freeze", aliens_freeze, 1);
        chk("over_lives", lives, 0);
        player_died = 1'b1;
        step();
        player_died = 1'b0;
        chk("over_die_lives", lives, 0);
        chk("over_hold", no_lives_left, 1);

        restart_gameN = 1'b0;
        step();
        restart_gameN = 1'b1;
        chk("restart_lives", lives, 3);
        chk("restart_awake", player_awake, 1);
        chk("restart_over", no_lives_left, 0);
        chk("restart_freeze", aliens_freeze, 0);

        // Restart wins over a simultaneous death
        restart_gameN = 1'b0;
        player_died   = 1'b1;
        step();
        restart_gameN = 1'b1;
        player_died   = 1'b0;
        chk("restart_vs_die_lives", lives, 3);
        chk("restart_vs_die_awake", player_awake, 1);

        // Restart mid-DYING reloads and clears the frame counter
        player_died = 1'b1;
        step();
        player_died = 1'b0;
        frames(10);
        restart_gameN = 1'b0;
        step();
        restart_gameN = 1'b1;
        chk("mid_restart_lives", lives, 3);
        chk("mid_restart_awake", player_awake, 1);
        chk("mid_restart_fc", dut.fc, 0);
        player_died = 1'b1;
        step();
        player_died = 1'b0;
        rs_cnt = 0;
        frames(59);
        chk("post_restart59_cnt", rs_cnt, 0);
        frames(1);
        chk("post_restart60_cnt", rs_cnt, 1);
        frames(90);
        chk("post_restart_awake", player_awake, 1);
        chk("post_restart_lives", lives, 2);

`ifdef LIFE_EXTRA_LIFE_EN
        restart_gameN = 1'b0;
        step();
        restart_gameN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            extra_life = 1'b1;
            step();
            extra_life = 1'b0;
            step();
        end
        chk("extra_sat_lives", lives, 5);

        restart_gameN = 1'b0;
        step();
        restart_gameN = 1'b1;
        die_and_respawn();
        die_and_respawn();
        chk("extra_pre_lives", lives, 1);
        player_died = 1'b1;
        step();
        player_died = 1'b0;
        chk("extra_dying_lives", lives, 0);
        rs_cnt = 0;
        frames(59);
        startOfFrame = 1'b1;
        extra_life   = 1'b1;
        step();
        startOfFrame = 1'b0;
        extra_life   = 1'b0;
        chk("extra_last_frame_respawn", respawn_pulse, 1);
        chk("extra_last_frame_lives", lives, 1);
        chk("extra_last_frame_over", no_lives_left, 0);
        step();
        frames(90);
        player_died = 1'b1;
        extra_life  = 1'b1;
        step();
        player_died = 1'b0;
        extra_life  = 1'b0;
        chk("extra_with_death_lives", lives, 1);
        chk("extra_with_death_awake", player_awake, 0);
`else
        extra_life = 1'b1;
        step();
        extra_life = 1'b0;
        step();
        chk("extra_ignored_lives", lives, 2);
        player_died = 1'b1;
        step();
        player_died = 1'b0;
        frames(5);
`endif

        // Asynchronous reset mid-sequence
        #2 resetN = 1'b0;
        #1;
        chk("async_rst_lives", lives, 3);
        chk("async_rst_awake", player_awake, 1);
        chk("async_rst_freeze", aliens_freeze, 0);
        #4 resetN = 1'b1;
        step();
        chk("async_rst_fc", dut.fc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
